// File: rtl/fifo_bank_pkg.sv
// Shared constants and helpers for the parametrised FIFO bank.
package fifo_bank_pkg;

  // Default build: two 8-deep byte-wide channels
  localparam int DEF_NUM_CH    = 2;
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_AF_THRESH = 6;
  localparam int DEF_AE_THRESH = 1;

  // Bit positions inside the per-channel sticky error vector
  localparam int ERR_OVF = 0;
  localparam int ERR_UNF = 1;
  localparam int ERR_W   = 2;

  // Count field must hold 0..DEPTH inclusive, hence one bit more than the pointer
  function automatic int clog2p1(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_chan.sv
// Single synchronous FIFO channel: memory, pointers, fill count, flags, sticky errors.
module fifo_chan
  import fifo_bank_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEF_AF_THRESH,
  parameter int AE_THRESH = DEF_AE_THRESH,
  localparam int CW       = clog2p1(DEPTH),
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             write,
  input  logic             read,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic [ERR_W-1:0] err;
  logic             wr_acc, rd_acc;

  // Flags derive from the registered count only
  assign empty        = (cnt == '0);
  assign full         = (cnt == CW'(DEPTH));
  assign almost_full  = (cnt >= CW'(AF_THRESH));
  assign almost_empty = (cnt <= CW'(AE_THRESH));
  assign count        = cnt;
  assign overflow     = err[ERR_OVF];
  assign underflow    = err[ERR_UNF];

  // A simultaneous read frees a slot, so a write into a full FIFO still lands.
  // Empty FIFO never bypasses write data to the read side.
  assign wr_acc = write && (!full || read);
  assign rd_acc = read && !empty;

  // Storage array; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

  // Pointers, count, registered read data and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      err       <= '0;
    end else begin
      valid_out <= rd_acc;
      if (rd_acc) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      cnt <= cnt + CW'(wr_acc) - CW'(rd_acc);
      if (write && full && !read) err[ERR_OVF] <= 1'b1;
      if (read && empty)          err[ERR_UNF] <= 1'b1;
    end
  end

endmodule

// File: rtl/fifo_bank_param.sv
// Bank of NUM_CH independent FIFO channels sharing one clock, with flat per-channel buses.
module fifo_bank_param
  import fifo_bank_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEF_AF_THRESH,
  parameter int AE_THRESH = DEF_AE_THRESH,
  localparam int CW       = clog2p1(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*WIDTH-1:0] data_in,
  input  logic [NUM_CH-1:0]       write,
  input  logic [NUM_CH-1:0]       read,
  output logic [NUM_CH*WIDTH-1:0] data_out,
  output logic [NUM_CH-1:0]       valid_out,
  output logic [NUM_CH-1:0]       empty,
  output logic [NUM_CH-1:0]       full,
  output logic [NUM_CH-1:0]       almost_full,
  output logic [NUM_CH-1:0]       almost_empty,
  output logic [NUM_CH*CW-1:0]    count,
  output logic [NUM_CH-1:0]       overflow,
  output logic [NUM_CH-1:0]       underflow
);

  // One fully independent channel per slice of the flat buses
  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    fifo_chan #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .AF_THRESH (AF_THRESH),
      .AE_THRESH (AE_THRESH)
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .data_in      (data_in[g*WIDTH +: WIDTH]),
      .write        (write[g]),
      .read         (read[g]),
      .data_out     (data_out[g*WIDTH +: WIDTH]),
      .valid_out    (valid_out[g]),
      .empty        (empty[g]),
      .full         (full[g]),
      .almost_full  (almost_full[g]),
      .almost_empty (almost_empty[g]),
      .count        (count[g*CW +: CW]),
      .overflow     (overflow[g]),
      .underflow    (underflow[g])
    );
  end

endmodule

// File: tb/tb_fifo_bank_param.sv
// Bench for fifo_bank_param: default build driven by directed sequences, a 4x16x16 build
// driven randomly; both checked every cycle against a queue-based model.
module tb_fifo_bank_param;

  localparam int A_CH = 2, A_W = 8,  A_D = 8,  A_AF = 6,  A_AE = 1, A_CW = 4;
  localparam int B_CH = 4, B_W = 16, B_D = 16, B_AF = 12, B_AE = 2, B_CW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default build
  logic                  rst_a = 1'b1;
  logic [A_CH-1:0]       wr_a = '0, rd_a = '0;
  logic [A_CH*A_W-1:0]   din_a = '0;
  logic [A_CH*A_W-1:0]   dout_a;
  logic [A_CH-1:0]       vld_a, emp_a, ful_a, afl_a, ael_a, ovf_a, unf_a;
  logic [A_CH*A_CW-1:0]  cnt_a;

  // wide build
  logic                  rst_b = 1'b1;
  logic [B_CH-1:0]       wr_b = '0, rd_b = '0;
  logic [B_CH*B_W-1:0]   din_b = '0;
  logic [B_CH*B_W-1:0]   dout_b;
  logic [B_CH-1:0]       vld_b, emp_b, ful_b, afl_b, ael_b, ovf_b, unf_b;
  logic [B_CH*B_CW-1:0]  cnt_b;

  fifo_bank_param dut_a (
    .clk(clk), .reset(rst_a), .data_in(din_a), .write(wr_a), .read(rd_a),
    .data_out(dout_a), .valid_out(vld_a), .empty(emp_a), .full(ful_a),
    .almost_full(afl_a), .almost_empty(ael_a), .count(cnt_a),
    .overflow(ovf_a), .underflow(unf_a)
  );

  fifo_bank_param #(.NUM_CH(B_CH), .WIDTH(B_W), .DEPTH(B_D), .AF_THRESH(B_AF), .AE_THRESH(B_AE)) dut_b (
    .clk(clk), .reset(rst_b), .data_in(din_b), .write(wr_b), .read(rd_b),
    .data_out(dout_b), .valid_out(vld_b), .empty(emp_b), .full(ful_b),
    .almost_full(afl_b), .almost_empty(ael_b), .count(cnt_b),
    .overflow(ovf_b), .underflow(unf_b)
  );

  int checks = 0, errors = 0;

  // Model: slots 0..3 belong to dut_a channels, 4..7 to dut_b channels
  logic [15:0] mq [8][$];
  logic [15:0] m_dout [8];
  bit          m_vld [8], m_ovf [8], m_unf [8];

  task automatic chk(string name, int slot, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s slot%0d got %0h expected %0h", name, slot, got, exp);
    end
  endtask

  task automatic mstep(int base, int nch, int depth, int width, logic rst,
                       logic [3:0] w, logic [3:0] r, logic [63:0] din);
    for (int ch = 0; ch < nch; ch++) begin
      int k;
      bit is_full, is_empty;
      logic [15:0] d;
      k = base + ch;
      if (rst) begin
        mq[k].delete();
        m_dout[k] = '0; m_vld[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
      end else begin
        is_full  = (mq[k].size() == depth);
        is_empty = (mq[k].size() == 0);
        d = 16'((din >> (ch*width)) & ((64'd1 << width) - 1));
        m_vld[k] = 0;
        if (r[ch] && !is_empty) begin
          m_dout[k] = mq[k].pop_front();
          m_vld[k]  = 1;
        end
        if (w[ch] && (!is_full || r[ch])) mq[k].push_back(d);
        if (w[ch] && is_full && !r[ch]) m_ovf[k] = 1;
        if (r[ch] && is_empty)          m_unf[k] = 1;
      end
    end
  endtask

  task automatic cmp_dut(int base, int nch, int width, int cw, int af, int ae,
                         logic [63:0] dout, logic [63:0] cnt, logic [3:0] vld,
                         logic [3:0] emp, logic [3:0] ful, logic [3:0] afl,
                         logic [3:0] ael, logic [3:0] ovf, logic [3:0] unf);
    for (int ch = 0; ch < nch; ch++) begin
      int k, sz;
      k  = base + ch;
      sz = mq[k].size();
      chk("count",        k, (cnt >> (ch*cw)) & ((64'd1 << cw) - 1), 64'(sz));
      chk("empty",        k, 64'(emp[ch]), 64'(sz == 0));
      chk("full",         k, 64'(ful[ch]), 64'(sz == (1 << (cw-1))));
      chk("almost_full",  k, 64'(afl[ch]), 64'(sz >= af));
      chk("almost_empty", k, 64'(ael[ch]), 64'(sz <= ae));
      chk("valid_out",    k, 64'(vld[ch]), 64'(m_vld[k]));
      chk("overflow",     k, 64'(ovf[ch]), 64'(m_ovf[k]));
      chk("underflow",    k, 64'(unf[ch]), 64'(m_unf[k]));
      chk("data_out",     k, (dout >> (ch*width)) & ((64'd1 << width) - 1), 64'(m_dout[k]));
    end
  endtask

  // Advance the model on the same edge the DUTs see
  always @(posedge clk) begin
    mstep(0, A_CH, A_D, A_W, rst_a, 4'(wr_a), 4'(rd_a), 64'(din_a));
    mstep(4, B_CH, B_D, B_W, rst_b, 4'(wr_b), 4'(rd_b), 64'(din_b));
  end

  // Every-cycle comparison, half a period after the edge
  always @(negedge clk) begin
    cmp_dut(0, A_CH, A_W, A_CW, A_AF, A_AE, 64'(dout_a), 64'(cnt_a), 4'(vld_a),
            4'(emp_a), 4'(ful_a), 4'(afl_a), 4'(ael_a), 4'(ovf_a), 4'(unf_a));
    cmp_dut(4, B_CH, B_W, B_CW, B_AF, B_AE, 64'(dout_b), 64'(cnt_b), 4'(vld_b),
            4'(emp_b), 4'(ful_b), 4'(afl_b), 4'(ael_b), 4'(ovf_b), 4'(unf_b));
  end

  // Apply one cycle of stimulus to dut_a; returns just after the consuming edge
  task automatic cyc_a(logic [1:0] w, logic [1:0] r, logic [7:0] d0, logic [7:0] d1);
    wr_a = w; rd_a = r; din_a = {d1, d0};
    @(posedge clk); #1;
    wr_a = '0; rd_a = '0;
  endtask

  int pulses;

  initial begin
    // reset then idle
    cyc_a(0, 0, 0, 0); cyc_a(0, 0, 0, 0);
    rst_a = 1'b0;
    cyc_a(0, 0, 0, 0);
    chk("lit_empty",    0, 64'(emp_a), 64'h3);
    chk("lit_aempty",   0, 64'(ael_a), 64'h3);
    chk("lit_count",    0, 64'(cnt_a), 64'h0);
    chk("lit_dout",     0, 64'(dout_a), 64'h0);
    chk("lit_full",     0, 64'(ful_a), 64'h0);

    // reset mid-operation
    cyc_a(2'b01, 0, 8'h01, 0); cyc_a(2'b01, 0, 8'h02, 0); cyc_a(2'b01, 0, 8'h03, 0);
    chk("lit_cnt3",     0, 64'(cnt_a[3:0]), 64'd3);
    rst_a = 1'b1; cyc_a(0, 0, 0, 0); rst_a = 1'b0;
    chk("lit_rst_cnt",  0, 64'(cnt_a[3:0]), 64'd0);
    chk("lit_rst_emp",  0, 64'(emp_a[0]), 64'd1);

    // three writes then three reads on ch0
    cyc_a(2'b01, 0, 8'hAA, 0); cyc_a(2'b01, 0, 8'h55, 0); cyc_a(2'b01, 0, 8'hFF, 0);
    pulses = 0;
    cyc_a(0, 2'b01, 0, 0); pulses += int'(vld_a[0]);
    chk("lit_rd_aa",    0, 64'(dout_a[7:0]), 64'hAA);
    cyc_a(0, 2'b01, 0, 0); pulses += int'(vld_a[0]);
    chk("lit_rd_55",    0, 64'(dout_a[7:0]), 64'h55);
    cyc_a(0, 2'b01, 0, 0); pulses += int'(vld_a[0]);
    chk("lit_rd_ff",    0, 64'(dout_a[7:0]), 64'hFF);
    cyc_a(0, 0, 0, 0); pulses += int'(vld_a[0]);
    chk("lit_pulses",   0, 64'(pulses), 64'd3);
    chk("lit_hold",     0, 64'(dout_a[7:0]), 64'hFF);
    chk("lit_ch1_emp",  1, 64'(emp_a[1]), 64'd1);

    // ch1 fill to full, overflow, drain across pointer wrap
    for (int i = 0; i < 8; i++) begin
      cyc_a(2'b10, 0, 0, 8'(8'h80 + i));
      if (i == 4) chk("lit_af_lo", 1, 64'(afl_a[1]), 64'd0);
      if (i == 5) chk("lit_af_hi", 1, 64'(afl_a[1]), 64'd1);
      if (i == 6) chk("lit_nfull", 1, 64'(ful_a[1]), 64'd0);
    end
    chk("lit_full1",    1, 64'(ful_a[1]), 64'd1);
    cyc_a(2'b10, 0, 0, 8'hEE);
    chk("lit_ovf1",     1, 64'(ovf_a[1]), 64'd1);
    chk("lit_cnt8",     1, 64'(cnt_a[7:4]), 64'd8);
    for (int i = 0; i < 8; i++) begin
      cyc_a(0, 2'b10, 0, 0);
      chk("lit_drain1", 1, 64'(dout_a[15:8]), 64'(8'h80 + i));
    end

    // ch0 full with simultaneous read+write
    for (int i = 0; i < 8; i++) cyc_a(2'b01, 0, 8'(8'h10 + i), 0);
    for (int i = 0; i < 4; i++) begin
      cyc_a(2'b01, 2'b01, 8'h99, 0);
      chk("lit_rw_dout", 0, 64'(dout_a[7:0]), 64'(8'h10 + i));
      chk("lit_rw_cnt",  0, 64'(cnt_a[3:0]), 64'd8);
      chk("lit_rw_ovf",  0, 64'(ovf_a[0]), 64'd0);
    end
    for (int i = 0; i < 8; i++) begin
      cyc_a(0, 2'b01, 0, 0);
      chk("lit_rw_drain", 0, 64'(dout_a[7:0]), (i < 4) ? 64'(8'h14 + i) : 64'h99);
    end

    // ch0 empty with simultaneous read+write: no bypass
    cyc_a(2'b01, 2'b01, 8'h3C, 0);
    chk("lit_unf",      0, 64'(unf_a[0]), 64'd1);
    chk("lit_unf_dout", 0, 64'(dout_a[7:0]), 64'h99);
    chk("lit_unf_vld",  0, 64'(vld_a[0]), 64'd0);
    chk("lit_unf_cnt",  0, 64'(cnt_a[3:0]), 64'd1);
    cyc_a(0, 2'b01, 0, 0);
    chk("lit_3c",       0, 64'(dout_a[7:0]), 64'h3C);

    // wide build: random interleaved traffic with biased fill/drain phases
    rst_b = 1'b0;
    @(posedge clk); #1;
    chk("lit_b_cnt",    4, 64'(cnt_b), 64'h0);
    for (int i = 0; i < 3000; i++) begin
      int pw;
      pw = ((i / 200) % 3 == 0) ? 75 : ((i / 200) % 3 == 1) ? 25 : 50;
      rst_b = (i == 1500);
      for (int ch = 0; ch < B_CH; ch++) begin
        wr_b[ch] = ($urandom_range(99) < pw);
        rd_b[ch] = ($urandom_range(99) < 100 - pw);
        din_b[ch*B_W +: B_W] = 16'($urandom);
      end
      @(posedge clk); #1;
    end
    rst_b = 1'b0; wr_b = '0; rd_b = '0;
    @(posedge clk); #1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
